seg_scan_decoder: RTL and testbench

Readback decoder for the stopwatch's multiplexed 7-segment display bus: samples segment lines and one-hot digit-select lines, waits for a stable pattern, decodes it back to a hex nibble, and stores it per digit. It sits beside the display drivers as a self-check and monitor path, the inverse of the hex-to-segment encoding. Unknown patterns raise a sticky error with the offending digit index.

---
 rtl/seg_scan_decoder_if.sv | 27 ++
 rtl/seg_scan_decoder.sv | 158 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
// Display-readback bus: raw segment/digit-select lines in, decoded digits and status out.
`default_nettype none

interface seg_scan_decoder_if;
  logic        cfg_cathode_mode;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        err_clr;
  logic [15:0] digit_hex;
  logic [3:0]  digit_valid;
  logic        upd_pulse;
  logic [1:0]  upd_idx;
  logic        err_flag;
  logic [1:0]  err_idx;

  modport master (
    output cfg_cathode_mode, seg_in, an_in, err_clr,
    input  digit_hex, digit_valid, upd_pulse, upd_idx, err_flag, err_idx
  );

  modport slave (
    input  cfg_cathode_mode, seg_in, an_in, err_clr,
    output digit_hex, digit_valid, upd_pulse, upd_idx, err_flag, err_idx
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a stable multiplexed 7-segment pattern back to per-digit hex nibbles.
// Optional macro SEG_DEC_BLANK_EN: all-off pattern is treated as a blank digit instead of an error.
`default_nettype none

module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  seg_scan_decoder_if.slave  bus
);

  localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [6:0]  r_samp_seg;
  logic [6:0]  r_prev_seg;
  logic [3:0]  r_samp_an;
  logic [3:0]  r_prev_an;
  logic [15:0] r_digit_hex;
  logic [3:0]  r_digit_valid;
  logic        r_upd_pulse;
  logic [1:0]  r_upd_idx;
  logic        r_err_flag;
  logic [1:0]  r_err_idx;

  logic        w_onehot;
  logic        w_same;
  logic        w_restart;
  logic [7:0]  w_cnt_inc;
  logic        w_capture;
  logic [1:0]  w_idx;
  logic        w_known;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic        w_bad;

  assign w_onehot  = $onehot(r_samp_an);
  assign w_same    = (r_samp_seg == r_prev_seg) && (r_samp_an == r_prev_an);
  assign w_restart = (r_state == S_IDLE) || !w_same;
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  // A restart captures immediately only when a single sample is enough.
  assign w_capture = ((r_state == S_TRACK) && w_same && (w_cnt_inc >= c_STABLE)) ||
                     (w_restart && w_onehot && (c_STABLE <= 8'd1));

  always_comb begin
    case (r_samp_an)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_known = 1'b1;
    w_nib   = 4'h0;
    case (r_samp_seg)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h67: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_known = 1'b0;
    endcase
  end

`ifdef SEG_DEC_BLANK_EN
  assign w_blank = (r_samp_seg == 7'h00);
`else
  assign w_blank = 1'b0;
`endif

  assign w_bad = !w_known && !w_blank;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_samp_seg    <= 7'd0;
      r_prev_seg    <= 7'd0;
      r_samp_an     <= 4'd0;
      r_prev_an     <= 4'd0;
      r_digit_hex   <= 16'd0;
      r_digit_valid <= 4'd0;
      r_upd_pulse   <= 1'b0;
      r_upd_idx     <= 2'd0;
      r_err_flag    <= 1'b0;
      r_err_idx     <= 2'd0;
    end else begin
      r_samp_seg  <= bus.cfg_cathode_mode ? bus.seg_in : ~bus.seg_in;
      r_samp_an   <= bus.an_in;
      r_prev_seg  <= r_samp_seg;
      r_prev_an   <= r_samp_an;
      r_upd_pulse <= 1'b0;

      if (w_restart) begin
        if (w_onehot) begin
          r_cnt   <= 8'd1;
          r_state <= w_capture ? S_HOLD : S_TRACK;
        end else begin
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
      end else begin
        r_cnt <= w_cnt_inc;
        if (w_capture) r_state <= S_HOLD;
      end

      if (w_capture) begin
        r_upd_pulse <= 1'b1;
        r_upd_idx   <= w_idx;
        if (w_known) begin
          r_digit_hex[{w_idx, 2'b00} +: 4] <= w_nib;
          r_digit_valid[w_idx]             <= 1'b1;
        end else begin
          r_digit_valid[w_idx] <= 1'b0;
        end
      end

      // A new error outranks a coincident clear.
      if (w_capture && w_bad) begin
        r_err_flag <= 1'b1;
        r_err_idx  <= w_idx;
      end else if (bus.err_clr) begin
        r_err_flag <= 1'b0;
      end
    end
  end

  assign bus.digit_hex   = r_digit_hex;
  assign bus.digit_valid = r_digit_valid;
  assign bus.upd_pulse   = r_upd_pulse;
  assign bus.upd_idx     = r_upd_idx;
  assign bus.err_flag    = r_err_flag;
  assign bus.err_idx     = r_err_idx;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus randomized scan traffic vs. a reference model.
`default_nettype none

module tb_seg_scan_decoder;
  localparam int S = 4;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  bit   chk_en  = 1'b0;

  seg_scan_decoder_if u_if ();

  seg_scan_decoder #(.STABLE_CYCLES(S)) u_dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: run length of identical one-hot samples decides captures.
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [10:0] hist [$];
  logic [15:0] m_hex   = '0;
  logic [3:0]  m_valid = '0;
  logic        m_upd   = 1'b0;
  logic [1:0]  m_upd_idx = '0;
  logic        m_err   = 1'b0;
  logic [1:0]  m_err_idx = '0;
  bit          pend    = 1'b0;
  logic [10:0] pend_s  = '0;

  always @(posedge sys_clk) begin
    if (!reset_n) begin
      m_hex = '0; m_valid = '0; m_upd = 1'b0; m_upd_idx = '0; m_err = 1'b0; m_err_idx = '0;
      pend = 1'b0;
      hist.delete();
    end else begin
      int run;
      int di;
      int found;
      logic [6:0] p;
      logic [3:0] a;
      bit err_set;
      m_upd   = 1'b0;
      err_set = 1'b0;
      if (pend) begin
        p  = pend_s[6:0];
        a  = pend_s[10:7];
        di = (a == 4'b0010) ? 1 : (a == 4'b0100) ? 2 : (a == 4'b1000) ? 3 : 0;
        m_upd = 1'b1;
        m_upd_idx = 2'(di);
        found = -1;
        for (int k = 0; k < 16; k++) if (seg_tab[k] == p) found = k;
        if (found >= 0) begin
          m_hex[di*4 +: 4] = 4'(found);
          m_valid[di] = 1'b1;
        end else begin
          m_valid[di] = 1'b0;
`ifdef SEG_DEC_BLANK_EN
          if (p != 7'h00) err_set = 1'b1;
`else
          err_set = 1'b1;
`endif
        end
      end
      if (err_set) begin
        m_err = 1'b1;
        m_err_idx = 2'(di);
      end else if (u_if.err_clr) begin
        m_err = 1'b0;
      end
      p = u_if.cfg_cathode_mode ? u_if.seg_in : ~u_if.seg_in;
      hist.push_back({u_if.an_in, p});
      if (hist.size() > 300) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != hist[hist.size()-1]) break;
        run++;
      end
      pend   = $onehot(u_if.an_in) && (run == S);
      pend_s = {u_if.an_in, p};
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      checks++;
      if (u_if.digit_hex !== m_hex || u_if.digit_valid !== m_valid || u_if.upd_pulse !== m_upd ||
          u_if.upd_idx !== m_upd_idx || u_if.err_flag !== m_err || u_if.err_idx !== m_err_idx) begin
        errors++;
        $display("FAIL model t=%0t got hex=%h val=%b upd=%b/%0d err=%b/%0d exp hex=%h val=%b upd=%b/%0d err=%b/%0d",
                 $time, u_if.digit_hex, u_if.digit_valid, u_if.upd_pulse, u_if.upd_idx, u_if.err_flag,
                 u_if.err_idx, m_hex, m_valid, m_upd, m_upd_idx, m_err, m_err_idx);
      end
    end
  end

  task automatic drive(input bit cfg, input logic [3:0] an, input logic [6:0] pat);
    u_if.cfg_cathode_mode = cfg;
    u_if.an_in  = an;
    u_if.seg_in = cfg ? pat : ~pat;
  endtask

  task automatic go_idle();
    @(negedge sys_clk);
    u_if.an_in = 4'b0000;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    reset_n = 1'b0;
    drive(1'b1, 4'b0000, 7'h00);
    u_if.err_clr = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({u_if.digit_hex, u_if.digit_valid, u_if.upd_pulse, u_if.upd_idx, u_if.err_flag, u_if.err_idx} !== 26'd0) begin
      errors++;
      $display("FAIL reset_state got hex=%h val=%b upd=%b err=%b need all zero",
               u_if.digit_hex, u_if.digit_valid, u_if.upd_pulse, u_if.err_flag);
    end
    reset_n = 1'b1;
    chk_en  = 1'b1;
  endtask

  task automatic test_single_capture();
    int npulse = 0;
    int at = 0;
    @(negedge sys_clk);
    drive(1'b1, 4'b0001, 7'h3F);
    for (int i = 1; i <= 10; i++) begin
      @(negedge sys_clk);
      if (u_if.upd_pulse) begin npulse++; at = i; end
    end
    checks++;
    if (npulse != 1 || at != S + 1) begin
      errors++;
      $display("FAIL single_latency got pulses=%0d at=%0d need 1 at %0d", npulse, at, S + 1);
    end
    checks++;
    if (u_if.digit_hex[3:0] !== 4'h0 || u_if.digit_valid !== 4'b0001 || u_if.upd_idx !== 2'd0) begin
      errors++;
      $display("FAIL single_value got hex0=%h val=%b idx=%0d need 0 0001 0",
               u_if.digit_hex[3:0], u_if.digit_valid, u_if.upd_idx);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic [6:0] pats [4] = '{7'h06, 7'h5B, 7'h4F, 7'h66};
    int npulse = 0;
    int order_ok = 1;
    for (int d = 0; d < 4; d++) begin
      @(negedge sys_clk);
      drive(1'b0, 4'(1 << d), pats[d]);
      for (int c = 0; c < 5; c++) begin
        @(negedge sys_clk);
        if (u_if.upd_pulse) begin
          if (u_if.upd_idx !== 2'(npulse)) order_ok = 0;
          npulse++;
        end
      end
    end
    checks++;
    if (npulse != 4 || order_ok == 0) begin
      errors++;
      $display("FAIL scan_pulses got %0d (order_ok=%0d) need 4 in order", npulse, order_ok);
    end
    checks++;
    if (u_if.digit_hex !== 16'h4321 || u_if.digit_valid !== 4'b1111) begin
      errors++;
      $display("FAIL scan_value got hex=%h val=%b need 4321 1111", u_if.digit_hex, u_if.digit_valid);
    end
    go_idle();
  endtask

  task automatic test_unstable();
    int npulse = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge sys_clk);
      drive(1'b1, 4'b0010, t[0] ? 7'h67 : 7'h7F);
      for (int c = 0; c < S - 2; c++) begin
        @(negedge sys_clk);
        if (u_if.upd_pulse) npulse++;
      end
    end
    @(negedge sys_clk);
    drive(1'b1, 4'b0011, 7'h7F);
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      if (u_if.upd_pulse) npulse++;
    end
    checks++;
    if (npulse != 0 || u_if.digit_hex !== 16'h4321) begin
      errors++;
      $display("FAIL unstable got pulses=%0d hex=%h need 0 4321", npulse, u_if.digit_hex);
    end
    go_idle();
  endtask

  task automatic test_error();
    @(negedge sys_clk);
    drive(1'b1, 4'b0100, 7'h49);
    repeat (S + 3) @(negedge sys_clk);
    checks++;
    if (u_if.err_flag !== 1'b1 || u_if.err_idx !== 2'd2 || u_if.digit_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL err_set got flag=%b idx=%0d val2=%b need 1 2 0",
               u_if.err_flag, u_if.err_idx, u_if.digit_valid[2]);
    end
    u_if.err_clr = 1'b1;
    @(negedge sys_clk);
    u_if.err_clr = 1'b0;
    checks++;
    if (u_if.err_flag !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got flag=%b need 0", u_if.err_flag);
    end
    go_idle();
    drive(1'b1, 4'b0010, 7'h49);
    repeat (S) @(negedge sys_clk);
    u_if.err_clr = 1'b1;
    @(negedge sys_clk);
    u_if.err_clr = 1'b0;
    checks++;
    if (u_if.err_flag !== 1'b1 || u_if.err_idx !== 2'd1 || u_if.upd_pulse !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins got flag=%b idx=%0d upd=%b need 1 1 1",
               u_if.err_flag, u_if.err_idx, u_if.upd_pulse);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_and_blank();
    int npulse = 0;
    @(negedge sys_clk);
    drive(1'b1, 4'b0001, 7'h7D);
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    checks++;
    if ({u_if.digit_hex, u_if.digit_valid, u_if.upd_pulse, u_if.upd_idx, u_if.err_flag, u_if.err_idx} !== 26'd0) begin
      errors++;
      $display("FAIL reset_mid got hex=%h val=%b upd=%b err=%b need all zero",
               u_if.digit_hex, u_if.digit_valid, u_if.upd_pulse, u_if.err_flag);
    end
    drive(1'b1, 4'b0000, 7'h00);
    @(negedge sys_clk);
    drive(1'b1, 4'b1000, 7'h00);
    for (int c = 0; c < S + 4; c++) begin
      @(negedge sys_clk);
      if (u_if.upd_pulse) npulse++;
    end
    checks++;
`ifdef SEG_DEC_BLANK_EN
    if (npulse != 1 || u_if.digit_valid[3] !== 1'b0 || u_if.err_flag !== 1'b0) begin
      errors++;
      $display("FAIL blank got pulses=%0d val3=%b err=%b need 1 0 0", npulse, u_if.digit_valid[3], u_if.err_flag);
    end
`else
    if (npulse != 1 || u_if.err_flag !== 1'b1 || u_if.err_idx !== 2'd3) begin
      errors++;
      $display("FAIL blank_err got pulses=%0d err=%b idx=%0d need 1 1 3", npulse, u_if.err_flag, u_if.err_idx);
    end
`endif
    go_idle();
  endtask

  task automatic test_random();
    bit cfg = 1'b1;
    logic [6:0] pat;
    logic [3:0] an;
    for (int n = 0; n < 250; n++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 4) == 0) cfg = ~cfg;
      pat = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
      an  = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      drive(cfg, an, pat);
      for (int c = 0; c < int'($urandom_range(1, 9)); c++) begin
        u_if.err_clr = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) u_if.cfg_cathode_mode = ~u_if.cfg_cathode_mode;
        @(negedge sys_clk);
      end
      u_if.err_clr = 1'b0;
    end
  endtask

  initial begin
    u_if.err_clr = 1'b0;
    drive(1'b1, 4'b0000, 7'h00);
    test_reset();
    test_single_capture();
    test_back_to_back();
    test_unstable();
    test_error();
    test_reset_mid_and_blank();
    test_random();
    repeat (3) @(negedge sys_clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
